// File: rtl/cpu_defs.sv
// Shared pipeline definitions: reset vector, inter-stage bus widths and field offsets.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  // IF -> ID bus layout: {excp_adef, pc, inst}
  localparam int FS_TO_DS_BUS_WD = 65;
  localparam int EXCP_ADEF_BIT   = 64;
  localparam int PC_MSB          = 63;
  localparam int PC_LSB          = 32;
  localparam int INST_MSB        = 31;
  localparam int INST_LSB        = 0;

  // Reserved for a bundled {br_stall, br_taken, br_target} from ID.
  localparam int BR_BUS_WD = 34;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fs_inst_buf.sv
// One-entry skid register holding SRAM read data while the consumer back-pressures;
// the SRAM output is only valid the cycle after a request, so it must be caught then.
module fs_inst_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid_i,
  input  logic        out_ready_i,
  input  logic        flush_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        buf_valid_o
);

  logic [31:0] buf_q;
  logic        buf_valid_q;

  // Flush and handshake take priority over capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else if (flush_i || (in_valid_i && out_ready_i)) begin
      buf_valid_q <= 1'b0;
    end else if (in_valid_i && !out_ready_i && !buf_valid_q) begin
      buf_q       <= rdata_i;
      buf_valid_q <= 1'b1;
    end
  end

  assign data_o      = buf_valid_q ? buf_q : rdata_i;
  assign buf_valid_o = buf_valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: computes nextpc, drives the 1-cycle instruction SRAM and
// presents {excp_adef, pc, inst} to ID over a valid/allowin handshake.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       br_stall,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  // Handshake: a transfer to ID happens when fs_to_ds_valid && ds_allowin.
  // br_taken cancels the IF entry and forces IF open regardless of ds_allowin.

  logic        to_fs_valid_q;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_adef_q, fs_adef_d;

  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fetch_go;
  logic [31:0] nextpc;
  logic [31:0] buf_data;
  logic        buf_valid;
  logic [31:0] inst;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid_q || ds_allowin || br_taken;
  assign nextpc      = br_taken ? br_target : fs_pc_q + 32'd4;
  assign fetch_go    = to_fs_valid_q && !br_stall;

  assign inst_sram_en    = fetch_go && fs_allowin && !is_misaligned(nextpc);
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

  always_comb begin
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    fs_adef_d  = fs_adef_q;
    if (fs_allowin) begin
      fs_valid_d = fetch_go;
      fs_adef_d  = is_misaligned(nextpc);
      // A stall leaves fs_pc on the last fetched address so fetch resumes after it.
      if (fetch_go) fs_pc_d = nextpc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_valid_q <= 1'b0;
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= RESET_PC - 32'd4;
      fs_adef_q     <= 1'b0;
    end else begin
      to_fs_valid_q <= 1'b1;
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      fs_adef_q     <= fs_adef_d;
    end
  end

  fs_inst_buf u_inst_buf (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid_i  (fs_valid_q),
    .out_ready_i (ds_allowin),
    .flush_i     (br_taken),
    .rdata_i     (inst_sram_rdata),
    .data_o      (buf_data),
    .buf_valid_o (buf_valid)
  );

  assign inst = fs_adef_q ? 32'b0 : buf_data;

  assign fs_to_ds_valid                       = fs_valid_q && fs_ready_go && !br_taken;
  assign fs_to_ds_bus[EXCP_ADEF_BIT]          = fs_adef_q;
  assign fs_to_ds_bus[PC_MSB:PC_LSB]          = fs_pc_q;
  assign fs_to_ds_bus[INST_MSB:INST_LSB]      = inst;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a program-order stream model predicts every
// {adef, pc, inst} that ID should accept; a monitor compares at each handshake.
module tb_if_stage;
  import cpu_defs::*;

  localparam int          W   = FS_TO_DS_BUS_WD;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ds_allowin = 1'b1;
  logic          br_taken = 1'b0;
  logic [31:0]   br_target = 32'h0;
  logic          br_stall = 1'b0;
  logic          inst_sram_en;
  logic [3:0]    inst_sram_we;
  logic [31:0]   inst_sram_addr;
  logic [31:0]   inst_sram_wdata;
  logic [31:0]   inst_sram_rdata = 32'h0;
  logic          fs_to_ds_valid;
  logic [W-1:0]  fs_to_ds_bus;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_hs     = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .br_stall        (br_stall),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
  endfunction

  function automatic logic [W-1:0] entry(input logic [31:0] pc);
    logic adef;
    adef = (pc[1:0] != 2'b00);
    return {adef, pc, adef ? 32'h0 : mem_f(pc)};
  endfunction

  // Sequential fetch: the instruction after pc is pc+4 until a redirect.
  task automatic topup();
    logic [W-1:0] last;
    logic [31:0]  pc;
    while (exp_q.size() < 4) begin
      last = exp_q[$];
      pc   = last[PC_MSB:PC_LSB];
      exp_q.push_back(entry(pc + 32'd4));
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // SRAM: 1-cycle latency; output is garbage whenever no request was made.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem_f(inst_sram_addr) : $urandom();

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resetn && fs_to_ds_valid && ds_allowin) begin
      n_hs++;
      if (exp_q.size() == 0) check("bus_underflow", W'(1), W'(0));
      else check("bus", fs_to_ds_bus, exp_q.pop_front());
    end
    assert (!(br_taken && br_stall));
  end

  // ---------------- driver ----------------
  task automatic rand_cycle(input bit allow_br);
    logic [31:0] tgt;
    @(posedge clk); #1;
    ds_allowin = ($urandom_range(0, 9) < 7);
    br_stall   = ($urandom_range(0, 9) == 0);
    br_taken   = allow_br && !br_stall && ($urandom_range(0, 9) == 0);
    tgt = RPC + (32'($urandom_range(0, 4095)) << 2);
    if ($urandom_range(0, 7) == 0) tgt = tgt + 32'($urandom_range(1, 3));
    br_target = tgt;
    if (br_taken) begin
      exp_q.delete();
      exp_q.push_back(entry(tgt));
    end
    topup();
    #1;
    check("we_wdata", W'({inst_sram_we, inst_sram_wdata}), W'(0));
    if (br_stall) check("stall_no_req", W'(inst_sram_en), W'(0));
    if (br_taken) begin
      check("br_kill_valid", W'(fs_to_ds_valid), W'(0));
      check("br_req_en", W'(inst_sram_en), W'(tgt[1:0] == 2'b00));
      if (tgt[1:0] == 2'b00) check("br_req_addr", W'(inst_sram_addr), W'(tgt));
    end
  endtask

  initial begin
    exp_q.push_back(entry(RPC));
    topup();
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", W'(inst_sram_en), W'(0));
    check("rst_valid", W'(fs_to_ds_valid), W'(0));
    resetn = 1'b1;
    #1;
    check("c1_en", W'(inst_sram_en), W'(0));
    @(posedge clk); #2;
    check("c2_en", W'(inst_sram_en), W'(1));
    check("c2_addr", W'(inst_sram_addr), W'(RPC));
    check("c2_valid", W'(fs_to_ds_valid), W'(0));
    @(posedge clk); #2;
    check("c3_valid", W'(fs_to_ds_valid), W'(1));
    check("c3_pc", W'(fs_to_ds_bus[PC_MSB:PC_LSB]), W'(RPC));
    check("c3_addr", W'(inst_sram_addr), W'(RPC + 32'd4));

    for (int i = 0; i < 600; i++) rand_cycle(1'b1);

    // Asynchronous reset between edges must drop outputs immediately.
    @(posedge clk); #3;
    resetn   = 1'b0;
    br_taken = 1'b0;
    br_stall = 1'b0;
    #1;
    check("async_rst_en", W'(inst_sram_en), W'(0));
    check("async_rst_valid", W'(fs_to_ds_valid), W'(0));
    exp_q.delete();
    exp_q.push_back(entry(RPC));
    topup();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rand_cycle(1'b0);

    for (int i = 0; i < 600; i++) rand_cycle(1'b1);

    check("liveness", W'(n_hs >= 300), W'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
